// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants and helpers for the multi-channel Galois
//               LFSR bank: maximal-length default tap masks, the Galois
//               right-shift step function and a clog2 helper that never
//               returns less than 1.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Widest LFSR the step helper can handle; callers zero-extend into it.
    localparam int c_MAX_W = 64;

    // Maximal-length Galois right-shift tap masks.
    localparam logic [7:0]  c_TAPS_8  = 8'hB8;
    localparam logic [15:0] c_TAPS_16 = 16'hB400;
    localparam logic [23:0] c_TAPS_24 = 24'hE10000;
    localparam logic [31:0] c_TAPS_32 = 32'h80200003;

    // One Galois step. Operands are zero-extended to c_MAX_W, so the upper
    // bits of the result stay zero and the caller truncates back to N.
    function automatic logic [c_MAX_W-1:0] galois_step(
        input logic [c_MAX_W-1:0] s,
        input logic [c_MAX_W-1:0] taps
    );
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

    // Index width for n items; a single item still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_bank_if
// Description : Bus bundle for lfsr_bank: seed-load port, per-channel
//               enables, the valid/ready random-number stream and the sticky
//               per-channel wrap flags.
// Modports    : master - the bank (drives the stream and wrap flags)
//               slave  - the user (loads seeds, enables, consumes stream)
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_bank_if
    import lfsr_pkg::*;
#(
    parameter int N      = 32,
    parameter int NUM_CH = 4,
    parameter int CW     = clog2_min1(NUM_CH)
);

    logic              seed_load;
    logic [CW-1:0]     seed_ch;
    logic [N-1:0]      seed_data;
    logic [NUM_CH-1:0] ch_en;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_data;
    logic [CW-1:0]     out_ch;
    logic [NUM_CH-1:0] wrapped;

    modport master (
        input  seed_load, seed_ch, seed_data, ch_en, out_ready,
        output out_valid, out_data, out_ch, wrapped
    );

    modport slave (
        output seed_load, seed_ch, seed_data, ch_en, out_ready,
        input  out_valid, out_data, out_ch, wrapped
    );

endinterface : lfsr_bank_if
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_core
// Description : One Galois LFSR channel. Holds the running state, the seed
//               it was loaded with, an armed bit (set by the first load) and
//               a sticky wrapped flag raised when a step returns the state to
//               the seed. A load takes priority over a step.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               i_load         - load i_load_data as seed and state
//               i_load_data    - seed value (0 is replaced by 1)
//               i_step         - advance the state by one Galois step
//               o_state        - current state
//               o_armed        - channel has been seeded since reset
//               o_wrapped      - state has returned to its seed
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int           N    = 32,
    parameter logic [N-1:0] TAPS = N'(c_TAPS_32)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    input  wire logic         i_load,
    input  wire logic [N-1:0] i_load_data,
    input  wire logic         i_step,
    output logic [N-1:0]      o_state,
    output logic              o_armed,
    output logic              o_wrapped
);

    logic [N-1:0] r_state;
    logic [N-1:0] r_seed;
    logic         r_armed;
    logic         r_wrapped;

    logic [N-1:0] w_seed;
    logic [N-1:0] w_next;

    // An all-zero state is a fixed point of the LFSR, so it is never loaded.
    assign w_seed = (i_load_data == '0) ? N'(1) : i_load_data;
    assign w_next = N'(galois_step(c_MAX_W'(r_state), c_MAX_W'(TAPS)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= '0;
            r_seed    <= '0;
            r_armed   <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (i_load) begin
            r_state   <= w_seed;
            r_seed    <= w_seed;
            r_armed   <= 1'b1;
            r_wrapped <= 1'b0;
        end else if (i_step) begin
            r_state <= w_next;
            if (w_next == r_seed) begin
                r_wrapped <= 1'b1;
            end
        end
    end

    assign o_state   = r_state;
    assign o_armed   = r_armed;
    assign o_wrapped = r_wrapped;

endmodule : lfsr_core
`default_nettype wire

// File: rtl/lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_bank
// Description : NUM_CH independent Galois LFSRs behind one round-robin
//               arbiter feeding a single registered valid/ready stream. Each
//               captured word is the channel state before its step, so every
//               number is emitted exactly once.
// Ports       : clk        - system clock, rising edge
//               reset      - synchronous active-high reset
//               bus.master - seed load, channel enables, output stream,
//                            sticky wrap flags (see lfsr_bank_if)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int           N      = 32,
    parameter int           NUM_CH = 4,
    parameter logic [N-1:0] TAPS   = N'(c_TAPS_32),
    parameter int           CW     = clog2_min1(NUM_CH)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    lfsr_bank_if.master bus
);

    logic [N-1:0]      w_state [NUM_CH];
    logic [NUM_CH-1:0] w_armed;
    logic [NUM_CH-1:0] w_wrapped;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_step;
    logic [NUM_CH-1:0] w_elig;

    logic              w_found;
    logic [CW-1:0]     w_sel;
    logic              w_capture;
    logic [CW-1:0]     w_rr_next;

    logic              r_out_valid;
    logic [N-1:0]      r_out_data;
    logic [CW-1:0]     r_out_ch;
    logic [CW-1:0]     r_rr_ptr;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            // Out-of-range seed_ch never matches any channel index.
            assign w_load[i] = bus.seed_load && (bus.seed_ch == CW'(i));
            assign w_step[i] = w_capture && (w_sel == CW'(i));
            // A channel being reloaded is skipped so the load always wins.
            assign w_elig[i] = w_armed[i] && bus.ch_en[i] && !w_load[i];

            lfsr_core #(
                .N    (N),
                .TAPS (TAPS)
            ) u_core (
                .clk         (clk),
                .reset       (reset),
                .i_load      (w_load[i]),
                .i_load_data (bus.seed_data),
                .i_step      (w_step[i]),
                .o_state     (w_state[i]),
                .o_armed     (w_armed[i]),
                .o_wrapped   (w_wrapped[i])
            );
        end
    endgenerate

    // Round-robin search: first eligible channel at or after r_rr_ptr.
    always_comb begin
        int            v_sum;
        logic [CW-1:0] v_idx;
        w_found = 1'b0;
        w_sel   = '0;
        v_sum   = 0;
        v_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_sum = int'(r_rr_ptr) + k;
            if (v_sum >= NUM_CH) begin
                v_sum = v_sum - NUM_CH;
            end
            v_idx = CW'(v_sum);
            if (!w_found && w_elig[v_idx]) begin
                w_found = 1'b1;
                w_sel   = v_idx;
            end
        end
    end

    assign w_capture = (!r_out_valid || bus.out_ready) && w_found;
    assign w_rr_next = (w_sel == CW'(NUM_CH - 1)) ? '0 : w_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_state[w_sel];
            r_out_ch    <= w_sel;
            r_rr_ptr    <= w_rr_next;
        end else if (bus.out_ready) begin
            // Word consumed (or none held) and nothing eligible to replace it.
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.wrapped   = w_wrapped;

endmodule : lfsr_bank
`default_nettype wire

// File: tb/tb_lfsr_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_bank
// Description : Self-checking bench for lfsr_bank (N=8, NUM_CH=2, TAPS=B8).
//               Directed scenarios use hand-derived sequences; a random
//               scenario is compared cycle by cycle against a behavioural
//               model of the bank kept in this file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_bank;
    import lfsr_pkg::*;

    localparam int c_N  = 8;
    localparam int c_CH = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    lfsr_bank_if #(.N(c_N), .NUM_CH(c_CH), .CW(1)) bus ();

    lfsr_bank #(
        .N      (c_N),
        .NUM_CH (c_CH),
        .TAPS   (8'hB8),
        .CW     (1)
    ) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // ---------------- behavioural model ----------------
    logic [7:0] m_state [2];
    logic [7:0] m_seed  [2];
    logic       m_armed [2];
    logic       m_wrap  [2];
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ch;
    int         m_rr;

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        int v;
        v = int'(s);
        return 8'((v / 2) ^ (((v % 2) == 1) ? 'hB8 : 0));
    endfunction

    // Advance one clock: predict from the inputs now applied, then commit
    // the prediction once the edge has passed.
    task automatic tick();
        logic [7:0] n_state [2];
        logic [7:0] n_seed  [2];
        logic       n_armed [2];
        logic       n_wrap  [2];
        logic       n_valid;
        logic [7:0] n_data;
        logic       n_ch;
        int         n_rr;
        logic       ld   [2];
        logic       elig [2];
        int         sel;
        int         c;
        logic       cap;
        n_state = m_state; n_seed = m_seed; n_armed = m_armed; n_wrap = m_wrap;
        n_valid = m_valid; n_data = m_data; n_ch = m_ch; n_rr = m_rr;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                n_state[i] = 0; n_seed[i] = 0; n_armed[i] = 0; n_wrap[i] = 0;
            end
            n_valid = 0; n_data = 0; n_ch = 0; n_rr = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                ld[i]   = bus.seed_load && (int'(bus.seed_ch) == i);
                elig[i] = m_armed[i] && bus.ch_en[i] && !ld[i];
            end
            sel = -1;
            for (int k = 0; k < 2; k++) begin
                c = (m_rr + k) % 2;
                if (sel < 0 && elig[c]) sel = c;
            end
            cap = (!m_valid || bus.out_ready) && (sel >= 0);
            if (cap) begin
                n_valid = 1;
                n_data  = m_state[sel];
                n_ch    = 1'(sel);
                n_state[sel] = ref_step(m_state[sel]);
                if (n_state[sel] == m_seed[sel]) n_wrap[sel] = 1;
                n_rr = (sel + 1) % 2;
            end else if (m_valid && bus.out_ready) begin
                n_valid = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (ld[i]) begin
                    n_state[i] = (bus.seed_data == 0) ? 8'h01 : bus.seed_data;
                    n_seed[i]  = n_state[i];
                    n_armed[i] = 1;
                    n_wrap[i]  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        m_state = n_state; m_seed = n_seed; m_armed = n_armed; m_wrap = n_wrap;
        m_valid = n_valid; m_data = n_data; m_ch = n_ch; m_rr = n_rr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.seed_load = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic ch, input logic [7:0] data);
        bus.seed_load = 1'b1;
        bus.seed_ch   = ch;
        bus.seed_data = data;
        tick();
        bus.seed_load = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.ch_en = 2'b00; bus.out_ready = 1'b1;
        bus.seed_ch = 1'b0; bus.seed_data = 8'h00;
        do_reset();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.out_data); end
        n_cmp++; if (bus.out_ch !== 1'b0) begin n_fail++; $display("FAIL reset_ch: got %b want 0", bus.out_ch); end
        n_cmp++; if (bus.wrapped !== 2'b00) begin n_fail++; $display("FAIL reset_wrapped: got %b want 00", bus.wrapped); end
    endtask

    task automatic test_single();
        logic [7:0] exp [6];
        exp = '{8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        do_reset();
        bus.ch_en = 2'b01; bus.out_ready = 1'b1;
        load(1'b0, 8'h01);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency: valid %b one cycle after load, want 0", bus.out_valid); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] || bus.out_ch !== 1'b0) begin
                n_fail++; $display("FAIL single_word[%0d]: got v=%b ch=%b d=%h want v=1 ch=0 d=%h", i, bus.out_valid, bus.out_ch, bus.out_data, exp[i]);
            end
        end
    endtask

    task automatic test_zero_seed();
        do_reset();
        bus.ch_en = 2'b01; bus.out_ready = 1'b1;
        load(1'b0, 8'h00);
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
            n_fail++; $display("FAIL zero_seed: got v=%b d=%h want v=1 d=01", bus.out_valid, bus.out_data);
        end
    endtask

    task automatic test_round_robin();
        logic       exp_ch [6];
        logic [7:0] exp_d  [6];
        exp_ch = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_d  = '{8'h01, 8'h80, 8'hB8, 8'h40, 8'h5C, 8'h20};
        do_reset();
        bus.ch_en = 2'b11; bus.out_ready = 1'b1;
        load(1'b0, 8'h01);
        load(1'b1, 8'h80);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ch !== exp_ch[i] || bus.out_data !== exp_d[i]) begin
                n_fail++; $display("FAIL rr_word[%0d]: got ch=%b d=%h want ch=%b d=%h", i, bus.out_ch, bus.out_data, exp_ch[i], exp_d[i]);
            end
        end
    endtask

    // Continues from the round-robin state: ch0 next 2E, ch1 next 10.
    task automatic test_backpressure();
        logic [7:0] exp_d [3];
        exp_d = '{8'h17, 8'hB3, 8'hE1};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b1 || bus.out_data !== 8'h20) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b ch=%b d=%h want v=1 ch=1 d=20", i, bus.out_valid, bus.out_ch, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_ch !== 1'b0 || bus.out_data !== 8'h2E) begin
            n_fail++; $display("FAIL bp_release0: got ch=%b d=%h want ch=0 d=2E", bus.out_ch, bus.out_data);
        end
        tick();
        n_cmp++; if (bus.out_ch !== 1'b1 || bus.out_data !== 8'h10) begin
            n_fail++; $display("FAIL bp_release1: got ch=%b d=%h want ch=1 d=10", bus.out_ch, bus.out_data);
        end
        bus.ch_en = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b0 || bus.out_data !== exp_d[i]) begin
                n_fail++; $display("FAIL bp_disable[%0d]: got ch=%b d=%h want ch=0 d=%h", i, bus.out_ch, bus.out_data, exp_d[i]);
            end
        end
    endtask

    task automatic test_period();
        do_reset();
        bus.ch_en = 2'b01; bus.out_ready = 1'b1;
        load(1'b0, 8'h01);
        for (int i = 1; i <= 256; i++) begin
            tick();
            n_cmp++; if (bus.wrapped[0] !== (i >= 255)) begin
                n_fail++; $display("FAIL period_wrapped[%0d]: got %b want %b", i, bus.wrapped[0], (i >= 255));
            end
        end
        n_cmp++; if (bus.out_data !== 8'h01) begin
            n_fail++; $display("FAIL period_word256: got %h want 01", bus.out_data);
        end
        load(1'b0, 8'h5A);
        n_cmp++; if (bus.wrapped[0] !== 1'b0) begin
            n_fail++; $display("FAIL period_reload_clear: got %b want 0", bus.wrapped[0]);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pre: got v=%b want 1", bus.out_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.wrapped !== 2'b00 || bus.out_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_clear: got v=%b w=%b d=%h want v=0 w=00 d=00", bus.out_valid, bus.wrapped, bus.out_data);
        end
        bus.ch_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL rstmid_idle[%0d]: got v=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_collision();
        do_reset();
        bus.ch_en = 2'b11; bus.out_ready = 1'b1;
        load(1'b0, 8'h01);
        load(1'b1, 8'h80);
        tick();
        n_cmp++; if (bus.out_ch !== 1'b1 || bus.out_data !== 8'h80) begin
            n_fail++; $display("FAIL coll_pre: got ch=%b d=%h want ch=1 d=80", bus.out_ch, bus.out_data);
        end
        load(1'b0, 8'h33);
        n_cmp++; if (bus.out_ch !== 1'b1 || bus.out_data !== 8'h40) begin
            n_fail++; $display("FAIL coll_skip: got ch=%b d=%h want ch=1 d=40", bus.out_ch, bus.out_data);
        end
        tick();
        n_cmp++; if (bus.out_ch !== 1'b0 || bus.out_data !== 8'h33) begin
            n_fail++; $display("FAIL coll_newseed: got ch=%b d=%h want ch=0 d=33", bus.out_ch, bus.out_data);
        end
        bus.out_ready = 1'b0;
        load(1'b0, 8'h77);
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_ch !== 1'b0 || bus.out_data !== 8'h33) begin
            n_fail++; $display("FAIL coll_heldword: got v=%b ch=%b d=%h want v=1 ch=0 d=33", bus.out_valid, bus.out_ch, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_ch !== 1'b1 || bus.out_data !== 8'h20) begin
            n_fail++; $display("FAIL coll_next1: got ch=%b d=%h want ch=1 d=20", bus.out_ch, bus.out_data);
        end
        tick();
        n_cmp++; if (bus.out_ch !== 1'b0 || bus.out_data !== 8'h77) begin
            n_fail++; $display("FAIL coll_next0: got ch=%b d=%h want ch=0 d=77", bus.out_ch, bus.out_data);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            bus.seed_load = ($urandom_range(0, 7) == 0);
            bus.seed_ch   = 1'($urandom_range(0, 1));
            bus.seed_data = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus.ch_en = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            n_cmp++; if (bus.out_valid !== m_valid || bus.out_data !== m_data || bus.out_ch !== m_ch || bus.wrapped !== {m_wrap[1], m_wrap[0]}) begin
                n_fail++; $display("FAIL random[%0d]: got v=%b ch=%b d=%h w=%b want v=%b ch=%b d=%h w=%b", i,
                    bus.out_valid, bus.out_ch, bus.out_data, bus.wrapped, m_valid, m_ch, m_data, {m_wrap[1], m_wrap[0]});
            end
        end
        rst = 1'b0;
        bus.seed_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.seed_load = 1'b0; bus.seed_ch = 1'b0; bus.seed_data = 8'h00;
        bus.ch_en = 2'b00; bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_seed[i] = 0; m_armed[i] = 0; m_wrap[i] = 0;
        end
        m_valid = 0; m_data = 0; m_ch = 0; m_rr = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero_seed();
        test_round_robin();
        test_backpressure();
        test_period();
        test_reset_mid();
        test_collision();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_lfsr_bank
`default_nettype wire

// File: doc/lfsr_bank.md
# lfsr_bank

Parametrised multi-channel pseudo-random number generator for the PRNG design, and the successor to the single-channel LFSR. It holds NUM_CH independent Galois LFSRs of width N. Each channel is seeded at run time and has its own enable. One arbiter serves the channels round-robin into a single registered valid/ready output stream. Each channel also carries sticky full-period detection, and each number is consumed exactly once.

## Interface
Parameters:
- N, 32, LFSR width in bits (≥ 3).
- NUM_CH, 4, number of independent channels (≥ 1).
- TAPS, 32'h80200003, Galois right-shift feedback mask, N bits wide.
- CW, max(1, $clog2(NUM_CH)), channel index width (derived).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- seed_load  in  1  one-cycle pulse; loads seed_data into channel seed_ch.
- seed_ch  in  CW  target channel for seed_load.
- seed_data  in  N  seed value.
- ch_en  in  NUM_CH  per-channel enable; a disabled channel is never served or stepped.
- out_valid  out  1  out_data/out_ch hold a number.
- out_ready  in  1  consumer accepts the word when out_valid & out_ready.
- out_data  out  N  random number (channel state before its step).
- out_ch  out  CW  channel that produced out_data.
- wrapped  out  NUM_CH  sticky per-channel flag: state has returned to its seed.

## Operation
- Step function: s' = (s >> 1) ^ (s[0] ? TAPS : 0).
- Seed load:
  - The channel's state and seed register both take seed_data.
  - A seed of 0 is replaced by 1, which avoids lock-up.
  - The load sets armed[ch] and clears wrapped[ch].
  - seed_ch ≥ NUM_CH is ignored.
- A channel is eligible when armed & ch_en is set and it is not being loaded this cycle.
- Capture condition: (!out_valid | out_ready) and at least one channel is eligible.
  - Select the first eligible channel at or after rr_ptr, wrapping around.
  - Register its state into out_data and its index into out_ch, and set out_valid.
  - Step that channel's state in the same edge.
  - Set rr_ptr to the selected index + 1, modulo NUM_CH.
- If out_valid & out_ready and no channel is eligible, out_valid falls to 0.
- While out_valid & !out_ready: out_data, out_ch and all channel states hold; no stepping.
- Wrap detection: when a step produces a state equal to that channel's seed register, set wrapped[ch]. It stays set until reset or a reload of that channel.
- Simultaneous events:
  - Seed load and capture aimed at the same channel: the load wins. The channel is skipped this cycle and the arbiter picks the next eligible channel.
  - Reloading a channel whose word already sits in the output register does not alter that word.
- Reset, mid-operation or otherwise, clears:
  - all states, seed registers and armed bits;
  - wrapped, out_valid, out_data, out_ch and rr_ptr, all to 0.
  - Channels must be reloaded after reset.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, wrapped=0.
- Seed load at edge t: state is valid after t. If eligible and the output is free, the seed appears on out_data with out_valid=1 after edge t+1. Load-to-output latency is 2 cycles.
- Throughput: one word per cycle while out_ready=1 and any channel is eligible.
- wrapped[ch] rises on the same edge as the step that returns the state to the seed. For a maximal TAPS this is the period 2^N−1 step.
- ch_en changes take effect for the capture decision in the same cycle, combinational into the arbiter.

## Structure
- lfsr_pkg holds:
  - maximal-length default tap constants for N = 8, 16, 24 and 32 (8'hB8, 16'hB400, 24'hE10000, 32'h80200003);
  - the galois_step function;
  - a clog2-with-minimum-1 helper.
- Sub-module lfsr_core, instantiated NUM_CH times, holds one channel: state, seed register, armed, wrapped, load/step inputs and a state output.
- Arbiter, rr_ptr and output register live in the top level.

## Test plan
N=8, TAPS=8'hB8, NUM_CH=2 unless stated.
- Single channel: reset, load ch0 seed 8'h01, ch_en=2'b01, out_ready=1 -> out_data 01, B8, 5C, 2E, 17, B3 on consecutive cycles, out_ch=0, first word 2 cycles after the load.
- Zero seed: load ch0 with 8'h00 -> first out_data is 8'h01.
- Round-robin: ch0 seed 01, ch1 seed 80, ch_en=2'b11 -> (ch,data) sequence (0,01), (1,80), (0,B8), (1,40), (0,5C), (1,20).
- Backpressure: drop out_ready for 3 cycles mid-stream -> out_data and out_ch frozen, no values skipped or repeated after release; disabling ch1 mid-stream -> only ch0 words follow.
- Period: ch0 seed 01, stream continuously -> wrapped[0] rises exactly on the 255th handshake and the 256th word is 01. Reloading ch0 clears wrapped[0].
- Reset mid-stream with out_valid=1 -> after the next edge out_valid=0 and wrapped=0, with no output until a channel is reloaded. Also check a load and capture colliding on ch0 -> ch1 is served and ch0 restarts from the new seed.
